// File: rtl/single_cycle_cpu.sv
// single_cycle_cpu: 8-bit single-cycle core (decode, regfile, ALU, data memory); define CPU_HALT_EN to make cmd F a sticky halt
module single_cycle_cpu #(
  parameter int DATA_W  = 8,
  parameter int DMEM_AW = 4
) (
  input  logic              clk,
  input  logic              PCReset,
  output logic [7:0]        instr_addr,
  input  logic [15:0]       instr,
  output logic [3:0]        flags,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic              halted
);
  localparam int M = DATA_W - 1;
  logic [7:0]        pc_q, pc_d, pc_inc;
  logic [DATA_W-1:0] rf_q [16];
  logic [DATA_W-1:0] mem_q [2**DMEM_AW];
  logic [3:0]        flags_q, flags_d;
  logic [3:0]        cmd, ra, rb, imm4;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] a, b, opb, res;
  logic [DATA_W:0]   sum, diff;
  logic [DMEM_AW-1:0] ea;
  logic              cf, vf, rf_we, fl_we, mem_we, run;
  assign cmd  = instr[15:12];
  assign ra   = instr[11:8];
  assign rb   = instr[7:4];
  assign imm4 = instr[3:0];
  assign imm8 = instr[7:0];
  assign a    = rf_q[ra];
  assign b    = rf_q[rb];
  assign opb  = (cmd == 4'h5) ? DATA_W'(imm8) : b;
  assign sum  = {1'b0, a} + {1'b0, opb};
  assign diff = {1'b0, a} - {1'b0, b};
  assign ea   = DMEM_AW'(b + DATA_W'(imm4));
  assign pc_inc = pc_q + 8'd1;
`ifdef CPU_HALT_EN
  // HALT does not advance the PC; the core then freezes until reset
  logic halted_q;
  assign run    = !halted_q && (cmd != 4'hF);
  assign halted = halted_q;
  // sticky halt flag, cleared only by reset
  always_ff @(posedge clk or posedge PCReset)
    if (PCReset) halted_q <= 1'b0;
    else if (cmd == 4'hF) halted_q <= 1'b1;
`else
  assign run    = 1'b1;
  assign halted = 1'b0;
`endif
  // decode and execute: result, flag values, write enables and next PC
  always_comb begin
    res    = sum[M:0];
    cf     = 1'b0;
    vf     = 1'b0;
    rf_we  = 1'b0;
    fl_we  = 1'b0;
    mem_we = 1'b0;
    pc_d   = pc_inc;
    case (cmd)
      4'h0, 4'h5: begin
        res   = sum[M:0];
        cf    = sum[DATA_W];
        vf    = (a[M] == opb[M]) && (res[M] != a[M]);
        rf_we = 1'b1;
        fl_we = 1'b1;
      end
      4'h1, 4'h7: begin
        res   = diff[M:0];
        cf    = ~diff[DATA_W];
        vf    = (a[M] != b[M]) && (res[M] != a[M]);
        rf_we = (cmd == 4'h1);
        fl_we = 1'b1;
      end
      4'h2: begin res = a & b;  rf_we = 1'b1; fl_we = 1'b1; end
      4'h3: begin res = a | b;  rf_we = 1'b1; fl_we = 1'b1; end
      4'h4: begin res = a ^ b;  rf_we = 1'b1; fl_we = 1'b1; end
      4'h6: begin res = DATA_W'(imm8); rf_we = 1'b1; end
      4'h8: begin res = b << imm4; rf_we = 1'b1; fl_we = 1'b1; end
      4'h9: begin res = b >> imm4; rf_we = 1'b1; fl_we = 1'b1; end
      4'hA: begin res = mem_q[ea]; rf_we = 1'b1; end
      4'hB: mem_we = 1'b1;
      4'hC: pc_d = imm8;
      4'hD: pc_d = flags_q[2] ? imm8 : pc_inc;
      4'hE: pc_d = flags_q[2] ? pc_inc : imm8;
      default: ;
    endcase
    if (!run) begin
      rf_we  = 1'b0;
      fl_we  = 1'b0;
      mem_we = 1'b0;
      pc_d   = pc_q;
    end
  end
  assign flags_d = {res[M], res == '0, cf, vf};
  // architectural state: PC, flags and register file
  always_ff @(posedge clk or posedge PCReset)
    if (PCReset) begin
      pc_q    <= '0;
      flags_q <= '0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (fl_we) flags_q <= flags_d;
      if (rf_we) rf_q[ra] <= res;
    end
  // data memory: synchronous write, never reset
  always_ff @(posedge clk)
    if (mem_we) mem_q[ea] <= a;
  assign instr_addr = pc_q;
  assign flags      = flags_q;
  assign dbg_data   = rf_q[dbg_sel];
endmodule

// File: tb/tb_single_cycle_cpu.sv
// tb_single_cycle_cpu: directed vector table, corner sequences and random programs against an ISA-level model
module tb_single_cycle_cpu;
  logic        clk = 1'b0;
  logic        PCReset = 1'b1;
  logic [7:0]  instr_addr;
  logic [15:0] instr;
  logic [3:0]  flags;
  logic [3:0]  dbg_sel = 4'd0;
  logic [7:0]  dbg_data;
  logic        halted;
  logic [15:0] rom [256];
  int total = 0, bad = 0;
  int mr [16];
  int mmem [16];
  int mpc;
  logic [3:0] mflags;
  logic mhalt;
  typedef struct {
    logic [7:0]  addr;
    logic [15:0] ins;
    logic [7:0]  pc;
    logic [3:0]  sel;
    logic [7:0]  val;
    logic [3:0]  fl;
  } vec_t;
  vec_t tbl [18];
  single_cycle_cpu #(.DATA_W(8), .DMEM_AW(4)) dut (
    .clk(clk), .PCReset(PCReset), .instr_addr(instr_addr), .instr(instr),
    .flags(flags), .dbg_sel(dbg_sel), .dbg_data(dbg_data), .halted(halted)
  );
  assign instr = rom[instr_addr];
  always #50 clk = ~clk;
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask
  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction
  task automatic model_reset();
    mpc = 0;
    mflags = 4'h0;
    mhalt = 1'b0;
    for (int i = 0; i < 16; i++) mr[i] = 0;
  endtask
  task automatic model_step();
    logic [15:0] ins;
    int c, ai, bi, i4, i8, a, b, r, s, npc;
    bit wr, wf, cf, vf;
    ins = rom[mpc];
    c = int'(ins[15:12]); ai = int'(ins[11:8]); bi = int'(ins[7:4]);
    i4 = int'(ins[3:0]); i8 = int'(ins[7:0]);
    a = mr[ai]; b = mr[bi];
    r = 0; wr = 0; wf = 0; cf = 0; vf = 0;
    npc = (mpc + 1) % 256;
    if (mhalt) return;
    case (c)
      0, 5: begin
        if (c == 5) b = i8;
        r = a + b; cf = r > 255; s = sx(a) + sx(b); vf = s > 127 || s < -128; wr = 1; wf = 1;
      end
      1, 7: begin
        r = a - b; cf = a >= b; s = sx(a) - sx(b); vf = s > 127 || s < -128; wr = (c == 1); wf = 1;
      end
      2: begin r = a & b; wr = 1; wf = 1; end
      3: begin r = a | b; wr = 1; wf = 1; end
      4: begin r = a ^ b; wr = 1; wf = 1; end
      6: begin r = i8; wr = 1; end
      8: begin r = b << i4; wr = 1; wf = 1; end
      9: begin r = b >> i4; wr = 1; wf = 1; end
      10: begin r = mmem[(b + i4) % 16]; wr = 1; end
      11: mmem[(b + i4) % 16] = a;
      12: npc = i8;
      13: if (mflags[2]) npc = i8;
      14: if (!mflags[2]) npc = i8;
      default: begin
`ifdef CPU_HALT_EN
        mhalt = 1'b1;
        npc = mpc;
`endif
      end
    endcase
    r = r & 255;
    if (wf) mflags = {r >= 128, r == 0, cf, vf};
    if (wr) mr[ai] = r;
    mpc = npc;
  endtask
  task automatic check_state(input string tag);
    cmp({tag, "_pc"}, 32'(instr_addr), 32'(mpc));
    cmp({tag, "_flags"}, 32'(flags), 32'(mflags));
    cmp({tag, "_halted"}, 32'(halted), 32'(mhalt));
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i);
      #1;
      cmp($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(mr[i]));
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic step(input string tag);
    model_step();
    tick();
    check_state(tag);
  endtask
  task automatic do_reset();
    #10 PCReset = 1'b1;
    #10 PCReset = 1'b0;
    model_reset();
  endtask
  initial begin
    tbl[0]  = '{8'h00, 16'h617F, 8'h01, 4'h1, 8'h7F, 4'h0};
    tbl[1]  = '{8'h01, 16'h5101, 8'h02, 4'h1, 8'h80, 4'h9};
    tbl[2]  = '{8'h02, 16'h6280, 8'h03, 4'h2, 8'h80, 4'h9};
    tbl[3]  = '{8'h03, 16'h1120, 8'h04, 4'h1, 8'h00, 4'h6};
    tbl[4]  = '{8'h04, 16'h63F0, 8'h05, 4'h3, 8'hF0, 4'h6};
    tbl[5]  = '{8'h05, 16'h643C, 8'h06, 4'h4, 8'h3C, 4'h6};
    tbl[6]  = '{8'h06, 16'h2340, 8'h07, 4'h3, 8'h30, 4'h0};
    tbl[7]  = '{8'h07, 16'h8542, 8'h08, 4'h5, 8'hF0, 4'h8};
    tbl[8]  = '{8'h08, 16'h9648, 8'h09, 4'h6, 8'h00, 4'h4};
    tbl[9]  = '{8'h09, 16'h67A5, 8'h0A, 4'h7, 8'hA5, 4'h4};
    tbl[10] = '{8'h0A, 16'h6803, 8'h0B, 4'h8, 8'h03, 4'h4};
    tbl[11] = '{8'h0B, 16'hB782, 8'h0C, 4'h7, 8'hA5, 4'h4};
    tbl[12] = '{8'h0C, 16'hA982, 8'h0D, 4'h9, 8'hA5, 4'h4};
    tbl[13] = '{8'h0D, 16'h7770, 8'h0E, 4'h7, 8'hA5, 4'h6};
    tbl[14] = '{8'h0E, 16'hD020, 8'h20, 4'h7, 8'hA5, 4'h6};
    tbl[15] = '{8'h20, 16'hE040, 8'h21, 4'h7, 8'hA5, 4'h6};
    tbl[16] = '{8'h21, 16'hC0FF, 8'hFF, 4'h7, 8'hA5, 4'h6};
    tbl[17] = '{8'hFF, 16'h6A55, 8'h00, 4'hA, 8'h55, 4'h6};
    for (int i = 0; i < 256; i++) rom[i] = 16'h6F00;
    for (int i = 0; i < 18; i++) rom[tbl[i].addr] = tbl[i].ins;
    for (int i = 0; i < 16; i++) mmem[i] = 0;
    model_reset();
    #20 PCReset = 1'b0;
    check_state("reset");
    for (int i = 0; i < 18; i++) begin
      tick();
      cmp($sformatf("vec%0d_pc", i), 32'(instr_addr), 32'(tbl[i].pc));
      cmp($sformatf("vec%0d_flags", i), 32'(flags), 32'(tbl[i].fl));
      dbg_sel = tbl[i].sel;
      #1;
      cmp($sformatf("vec%0d_reg", i), 32'(dbg_data), 32'(tbl[i].val));
    end
    tick();
    #10 PCReset = 1'b1;
    #1;
    cmp("async_rst_pc", 32'(instr_addr), 32'h0);
    cmp("async_rst_flags", 32'(flags), 32'h0);
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i);
      #1;
      cmp($sformatf("async_rst_r%0d", i), 32'(dbg_data), 32'h0);
    end
    PCReset = 1'b0;
    model_reset();
    rom[8'h00] = 16'hC0FF;
    rom[8'hFF] = 16'hC000;
    step("b_to_ff");
    step("b_wrap");
    cmp("b_wrap_addr", 32'(instr_addr), 32'h0);
    do_reset();
    rom[0] = 16'h6105; rom[1] = 16'hF000; rom[2] = 16'h6109; rom[3] = 16'h6F00;
    for (int i = 0; i < 12; i++) step($sformatf("halt%0d", i));
`ifdef CPU_HALT_EN
    cmp("halt_held", 32'(halted), 32'h1);
    cmp("halt_pc", 32'(instr_addr), 32'h1);
    do_reset();
    cmp("halt_release", 32'(halted), 32'h0);
    cmp("halt_release_pc", 32'(instr_addr), 32'h0);
`else
    cmp("nop_halted", 32'(halted), 32'h0);
    cmp("nop_pc", 32'(instr_addr), 32'd12);
`endif
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rom[3*i]   = {4'h6, 4'h0, 8'($urandom)};
      rom[3*i+1] = {4'h6, 4'h1, 8'(i)};
      rom[3*i+2] = 16'hB010;
    end
    for (int i = 48; i < 256; i++)
      rom[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    for (int i = 0; i < 600; i++) step($sformatf("rnd%0d", i));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
